// File: rtl/sram_pixel_scanout_if.sv
// sram_pixel_scanout_if: RGB565 pixel stream with start/end-of-frame markers and ready/valid handshake
// Ports: data (pixel), sop (first pixel of frame), eop (last pixel of frame), valid, ready
interface sram_pixel_scanout_if;
  logic [15:0] data;
  logic sop;
  logic eop;
  logic valid;
  logic ready;
  modport master (output data, sop, eop, valid, input ready);
  modport slave (input data, sop, eop, valid, output ready);
endinterface

// File: rtl/sram_pixel_scanout.sv
// sram_pixel_scanout: linear SRAM pixel fetch into a show-ahead FIFO driving a ready/valid pixel stream
// Ports: clk; reset (async, active-high); enable starts/continues scanout (sampled in IDLE and at frame end);
//   sram_addr/sram_rdata/sram_*_n form the SRAM read port (data valid the cycle after the address);
//   stream (master) carries pixel data with sop/eop; swap_req/swap_done/cur_buffer control the
//   front/back buffer swap, compiled in only when SCANOUT_SWAP_EN is defined.
module sram_pixel_scanout #(
  parameter int WIDTH = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 18,
  parameter logic [ADDR_W-1:0] FRONT_BASE = 18'h00000,
  parameter logic [ADDR_W-1:0] BACK_BASE = 18'h20000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [15:0] sram_rdata,
  output logic sram_ce_n,
  output logic sram_oe_n,
  output logic sram_we_n,
  output logic sram_ub_n,
  output logic sram_lb_n,
  sram_pixel_scanout_if.master stream,
  input  logic swap_req,
  output logic swap_done,
  output logic cur_buffer
);
  localparam int FRAME = WIDTH * HEIGHT;
  localparam int PW = $clog2(FRAME);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PW-1:0] LAST = PW'(FRAME - 1);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;
  state_t state, state_n;
  logic [PW-1:0] pix;
  logic infl_v, infl_sop, infl_eop;
  logic [17:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic room, issue, frame_end, pop;
  logic [ADDR_W-1:0] base;
  assign sram_we_n = 1'b1;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign stream.valid = count != '0;
  assign {stream.sop, stream.eop, stream.data} = fifo_mem[rd_ptr];
  assign pop = stream.valid && stream.ready;
  // Counting the in-flight read against FIFO space guarantees a push never meets a full FIFO.
  always_comb begin
    room = 32'(count) + 32'(infl_v) < 32'(FIFO_DEPTH);
    issue = state != IDLE && room;
    frame_end = issue && pix == LAST;
    state_n = state == IDLE ? (enable ? FETCH : IDLE) :
              (frame_end && !enable) ? IDLE :
              room ? FETCH : WAIT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pix <= '0;
      sram_addr <= FRONT_BASE;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      infl_v <= 1'b0;
      infl_sop <= 1'b0;
      infl_eop <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      state <= state_n;
      sram_oe_n <= !issue;
      sram_ce_n <= !issue && state_n == IDLE;
      infl_v <= issue;
      infl_sop <= issue && pix == '0;
      infl_eop <= frame_end;
      if (issue) begin
        sram_addr <= base + ADDR_W'(pix);
        pix <= frame_end ? '0 : pix + PW'(1);
      end
      if (infl_v) begin
        fifo_mem[wr_ptr] <= {infl_sop, infl_eop, sram_rdata};
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(infl_v) - CW'(pop);
    end
  end
`ifdef SCANOUT_SWAP_EN
  logic pending, do_swap;
  // A request landing on the frame-end cycle is folded into that same frame end.
  assign do_swap = frame_end && (pending || swap_req);
  assign base = cur_buffer ? BACK_BASE : FRONT_BASE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      cur_buffer <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      pending <= !frame_end && (pending || swap_req);
      cur_buffer <= cur_buffer ^ do_swap;
      swap_done <= do_swap;
    end
  end
`else
  logic unused_swap;
  assign unused_swap = ^{swap_req, BACK_BASE};
  assign base = FRONT_BASE;
  assign cur_buffer = 1'b0;
  assign swap_done = 1'b0;
`endif
endmodule
